// File: rtl/pong_renderer_if.sv
// Pixel/game bus between the VGA scan side and the pong renderer.
// The master drives the scan position, sync and player inputs; the slave
// returns colour, scores and the game-over flag.
interface pong_renderer_if;
    logic [9:0] pixel_column;
    logic [9:0] pixel_row;
    logic       vert_sync;
    logic       btn_l_up;
    logic       btn_l_dn;
    logic       btn_r_up;
    logic       btn_r_dn;
    logic       start;
    logic [2:0] red_out;
    logic [2:0] green_out;
    logic [1:0] blue_out;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    modport master (
        output pixel_column, pixel_row, vert_sync,
        output btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start,
        input  red_out, green_out, blue_out, score_l, score_r, game_over
    );

    modport slave (
        input  pixel_column, pixel_row, vert_sync,
        input  btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start,
        output red_out, green_out, blue_out, score_l, score_r, game_over
    );
endinterface

// File: rtl/pong_renderer.sv
// Pong game logic and pixel colour stage feeding the VGA controller.
// Game state advances once per frame on the falling edge of vert_sync;
// the colour of the pixel being scanned is registered every clock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SERVE     | ball parked at centre, counting frames until the serve
// PLAY      | ball moving, walls/paddles/misses evaluated each frame
// GAME_OVER | a player reached the winning score; waits for start
module pong_renderer #(
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 4,
    parameter int PAD_H        = 64,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic            clk_50,
    input  logic            rst,
    pong_renderer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam logic [9:0]        BALL_X0    = 10'd316;
    localparam logic [9:0]        BALL_Y0    = 10'd236;
    localparam logic [9:0]        PAD_Y0     = 10'd208;
    localparam logic [9:0]        PAD_MAX    = 10'(480 - PAD_H);
    localparam logic [9:0]        PAD_STEP   = 10'(PAD_SPEED);
    localparam logic [10:0]       PAD_H11    = 11'(PAD_H);
    localparam logic signed [10:0] BALL_STEP = 11'(BALL_SPEED);
    localparam logic [7:0]        SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]        WIN        = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic        vs_q;
    logic [9:0]  bx_q, bx_d;
    logic [9:0]  by_q, by_d;
    logic        dx_q, dx_d;      // 1 = moving right
    logic        dy_q, dy_d;      // 1 = moving down
    logic [9:0]  pyl_q, pyl_d;
    logic [9:0]  pyr_q, pyr_d;
    logic [7:0]  srv_cnt_q, srv_cnt_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [2:0]  red_q, red_d;
    logic [2:0]  green_q, green_d;
    logic [1:0]  blue_q, blue_d;
    logic        game_over_w;
    logic        tick;

    logic signed [10:0] nx, ny;
    logic               hit_l, hit_r;

    assign tick = vs_q & ~bus.vert_sync;

    function automatic logic [9:0] pad_next(input logic [9:0] py,
                                            input logic up, input logic dn);
        logic [9:0] r;
        r = py;
        if (up && !dn)
            r = (py < PAD_STEP) ? 10'd0 : py - PAD_STEP;
        else if (dn && !up)
            r = (py > PAD_MAX - PAD_STEP) ? PAD_MAX : py + PAD_STEP;
        return r;
    endfunction

    function automatic logic overlaps(input logic [9:0] y, input logic [9:0] py);
        return (({1'b0, y} + 11'd8) > {1'b0, py}) &&
               ({1'b0, y} < ({1'b0, py} + PAD_H11));
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    // State register.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) state_q <= ST_SERVE;
        else     state_q <= state_d;
    end

    // Game datapath, colour and sync registers.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            vs_q      <= 1'b1;
            bx_q      <= BALL_X0;
            by_q      <= BALL_Y0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            pyl_q     <= PAD_Y0;
            pyr_q     <= PAD_Y0;
            srv_cnt_q <= 8'd0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            red_q     <= 3'd0;
            green_q   <= 3'd0;
            blue_q    <= 2'd0;
        end else begin
            vs_q      <= bus.vert_sync;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pyl_q     <= pyl_d;
            pyr_q     <= pyr_d;
            srv_cnt_q <= srv_cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    // Next-state: per-frame game update plus the start request in GAME_OVER.
    // Collisions use the paddle positions from before this frame's move.
    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        pyl_d     = pyl_q;
        pyr_d     = pyr_q;
        srv_cnt_d = srv_cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hit_l     = 1'b0;
        hit_r     = 1'b0;
        nx = dx_q ? ($signed({1'b0, bx_q}) + BALL_STEP) : ($signed({1'b0, bx_q}) - BALL_STEP);
        ny = dy_q ? ($signed({1'b0, by_q}) + BALL_STEP) : ($signed({1'b0, by_q}) - BALL_STEP);

        case (state_q)
            ST_SERVE: begin
                if (tick) begin
                    pyl_d = pad_next(pyl_q, bus.btn_l_up, bus.btn_l_dn);
                    pyr_d = pad_next(pyr_q, bus.btn_r_up, bus.btn_r_dn);
                    if (srv_cnt_q == SERVE_LAST) begin
                        srv_cnt_d = 8'd0;
                        state_d   = ST_PLAY;
                    end else begin
                        srv_cnt_d = srv_cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    pyl_d = pad_next(pyl_q, bus.btn_l_up, bus.btn_l_dn);
                    pyr_d = pad_next(pyr_q, bus.btn_r_up, bus.btn_r_dn);
                    if (ny < 11'sd0) begin
                        by_d = 10'd0;
                        dy_d = 1'b1;
                    end else if (ny > 11'sd472) begin
                        by_d = 10'd472;
                        dy_d = 1'b0;
                    end else begin
                        by_d = ny[9:0];
                    end
                    hit_l = !dx_q && (bx_q >= 10'd24) && (nx <= 11'sd24) && overlaps(by_d, pyl_q);
                    hit_r = dx_q && (bx_q <= 10'd608) && (nx >= 11'sd608) && overlaps(by_d, pyr_q);
                    if (hit_l) begin
                        bx_d = 10'd24;
                        dx_d = 1'b1;
                    end else if (hit_r) begin
                        bx_d = 10'd608;
                        dx_d = 1'b0;
                    end else if (nx < 11'sd0) begin
                        bx_d      = BALL_X0;
                        by_d      = BALL_Y0;
                        dx_d      = 1'b0;
                        score_r_d = sat_inc(score_r_q);
                        state_d   = (score_r_d == WIN) ? ST_GAME_OVER : ST_SERVE;
                    end else if (nx > 11'sd632) begin
                        bx_d      = BALL_X0;
                        by_d      = BALL_Y0;
                        dx_d      = 1'b1;
                        score_l_d = sat_inc(score_l_q);
                        state_d   = (score_l_d == WIN) ? ST_GAME_OVER : ST_SERVE;
                    end else begin
                        bx_d = nx[9:0];
                    end
                end
            end
            ST_GAME_OVER: begin
                if (bus.start) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    bx_d      = BALL_X0;
                    by_d      = BALL_Y0;
                    dx_d      = 1'b1;
                    srv_cnt_d = 8'd0;
                    state_d   = ST_SERVE;
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    // Outputs: game-over flag and next colour for the scanned pixel.
    always_comb begin
        logic [10:0] col, row;
        logic        on_ball, on_pad, on_line;
        col         = {1'b0, bus.pixel_column};
        row         = {1'b0, bus.pixel_row};
        game_over_w = (state_q == ST_GAME_OVER);
        on_ball = (col >= {1'b0, bx_q}) && (col < {1'b0, bx_q} + 11'd8) &&
                  (row >= {1'b0, by_q}) && (row < {1'b0, by_q} + 11'd8);
        on_pad  = ((col >= 11'd16) && (col <= 11'd23) &&
                   (row >= {1'b0, pyl_q}) && (row < {1'b0, pyl_q} + PAD_H11)) ||
                  ((col >= 11'd616) && (col <= 11'd623) &&
                   (row >= {1'b0, pyr_q}) && (row < {1'b0, pyr_q} + PAD_H11));
        on_line = (col >= 11'd318) && (col <= 11'd321) && !bus.pixel_row[4];
        red_d   = 3'd0;
        green_d = 3'd0;
        blue_d  = 2'd0;
        if ((col < 11'd640) && (row < 11'd480)) begin
            if (on_ball || on_pad) begin
                red_d   = 3'b111;
                green_d = 3'b111;
                blue_d  = 2'b11;
            end else if (on_line) begin
                red_d   = 3'b011;
                green_d = 3'b011;
                blue_d  = 2'b01;
            end else if (game_over_w) begin
                red_d   = 3'b100;
            end
        end
    end

    assign bus.red_out   = red_q;
    assign bus.green_out = green_q;
    assign bus.blue_out  = blue_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.game_over = game_over_w;

endmodule

// File: doc/pong_renderer.md
Name: pong_renderer

Overview:
- Game-logic and pixel-colour stage directly upstream of the VGA controller.
- Consumes the controller's pixel_column, pixel_row and vert_sync_out.
- Once per frame, updates ball, paddles, score and game state.
- Every clk_50 cycle, returns the registered 3/3/2 colour for the pixel currently being scanned.

Parameters:
- BALL_SPEED, 2, ball displacement per frame on each axis, in pixels.
- PAD_SPEED, 4, paddle displacement per frame, in pixels.
- PAD_H, 64, paddle height, in pixels.
- SERVE_FRAMES, 60, frames the ball waits at centre before a serve.
- WIN_SCORE, 9, score that ends the game.

Ports:
- clk_50  in  1  50 MHz system clock.
- rst  in  1  asynchronous active-high reset.
- pixel_column  in  10  current column from the VGA controller.
- pixel_row  in  10  current row from the VGA controller.
- vert_sync  in  1  vertical sync from the VGA controller; active low.
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  paddle buttons; level, already debounced.
- start  in  1  restart request, used in GAME_OVER only.
- red_out  out  3  pixel red.
- green_out  out  3  pixel green.
- blue_out  out  2  pixel blue.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- game_over  out  1  high while in GAME_OVER.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - Colour outputs 0; score_l = score_r = 0; game_over = 0; state SERVE.
  - Ball at (316,236), dx = +, dy = +.
  - Both paddle y = 208; serve counter = 0.
- Frame tick:
  - vert_sync is registered once; tick = one-cycle pulse on its falling edge.
  - All game state changes on tick only. The exception is start, which is sampled every cycle in GAME_OVER.
- Geometry:
  - Screen 640x480; ball 8x8 with top-left at (bx,by).
  - Left paddle occupies x 16..23; right paddle occupies x 616..623.
  - Paddle y range is py..py+PAD_H-1.
- Paddles (every tick, all states except GAME_OVER):
  - up only -> py -= PAD_SPEED; dn only -> py += PAD_SPEED; both or neither -> hold.
  - py clamps to 0..480-PAD_H; no wrap-around.
- State machine:
  - SERVE: ball held at centre; counter increments per tick. When counter reaches SERVE_FRAMES-1, counter clears, state -> PLAY.
  - PLAY, per tick: compute nx = bx ± BALL_SPEED and ny = by ± BALL_SPEED. Checks are evaluated in order:
    1. Walls: ny < 0 -> by = 0, dy = +. ny > 472 -> by = 472, dy = -. Otherwise by = ny.
    2. Left paddle: dx = -, bx ≥ 24, nx ≤ 24, and vertical overlap (by+8 > py_l and by < py_l+PAD_H) -> bx = 24, dx = +.
    3. Right paddle: dx = +, bx ≤ 608, nx ≥ 608, and overlap with py_r -> bx = 608, dx = -.
    4. Miss: nx < 0 (signed, 11-bit arithmetic) -> score_r += 1. nx > 632 -> score_l += 1.
    - After a miss: ball recentres, dx points toward the conceding player, dy unchanged. State -> GAME_OVER if the new score equals WIN_SCORE, else SERVE.
    - If no paddle hit and no miss, bx = nx.
  - GAME_OVER: game_over = 1; ball and paddles frozen. start = 1 -> scores cleared, ball centred, dx = +, state SERVE.
- Simultaneous events: wall and paddle reflection in the same tick both apply. Miss takes priority over paddle only when overlap fails.
- Scores saturate at WIN_SCORE.
- Pixel colour:
  - Registered on clk_50; latency 1 cycle from pixel_column/pixel_row.
  - Priority: ball -> 111/111/11; paddle -> 111/111/11.
  - Next, centre line (column 318..321 and pixel_row[4] = 0) -> 011/011/01.
  - Otherwise background: 000/000/00, or 100/000/00 while game_over.
  - Coordinates ≥ 640 columns or ≥ 480 rows -> 0.

Test Plan:
- Reset, then 59 vsync falling edges -> state SERVE, ball (316,236). 60th edge -> PLAY. Next tick -> ball (318,238).
- Hold btn_l_up for 60 frames from py = 208 -> py_l clamps at 0. Holding both buttons -> py unchanged.
- Ball at by = 1 moving up -> next tick by = 0, dy = +. Ball at by = 471 moving down -> by = 472, dy = -.
- Ball bx = 25, dx = -, py_l = by-4 -> bx = 24, dx = +. Same with py_l = by+20 but no overlap -> subsequent miss, score_r = 1, ball centred, SERVE.
- Force score_l = 8, ball exits right -> score_l = 9, game_over = 1, background red. start pulse -> scores 0, SERVE.
- pixel_column = 320, pixel_row = 5 -> next cycle colour 011/011/01. Assert rst mid-frame -> colour outputs 0 immediately.
